// File: rtl/decode_pkg.sv
// Shared types and field-offset helpers for the instruction decode stage.
// Instruction layout, MSB to LSB: regWithAddr, opCode, addr1, addr2, addrOut, type1, type2, outType.
package decode_pkg;

  typedef enum logic [1:0] {
    REG       = 2'b00,
    DIRECT    = 2'b01,
    INDIRECT  = 2'b10,
    IMMEDIATE = 2'b11
  } operand_type_e;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_e;

  localparam int TYPE_WIDTH = 2;

  function automatic int instruction_width(input int rw, input int ow, input int aw);
    return rw + ow + 3 * aw + 3 * TYPE_WIDTH;
  endfunction

  // Offsets counted from the LSB; the three type fields occupy the bottom bits.
  function automatic int out_type_lsb();
    return 0;
  endfunction

  function automatic int address2_type_lsb();
    return TYPE_WIDTH;
  endfunction

  function automatic int address1_type_lsb();
    return 2 * TYPE_WIDTH;
  endfunction

  function automatic int address_out_lsb();
    return 3 * TYPE_WIDTH;
  endfunction

  function automatic int address2_lsb(input int aw);
    return 3 * TYPE_WIDTH + aw;
  endfunction

  function automatic int address1_lsb(input int aw);
    return 3 * TYPE_WIDTH + 2 * aw;
  endfunction

  function automatic int opcode_lsb(input int aw);
    return 3 * TYPE_WIDTH + 3 * aw;
  endfunction

  function automatic int register_with_address_lsb(input int aw, input int ow);
    return 3 * TYPE_WIDTH + 3 * aw + ow;
  endfunction

endpackage

// File: rtl/decode_skid_buffer.sv
// Two-entry valid/ready buffer (main output register plus one skid register) over any packed type.
// hold freezes both sides without disturbing stored entries.
module decode_skid_buffer #(
  parameter type T = logic [7:0]
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  // Handshake: a word moves on a side exactly when valid && ready are both high at the
  // rising edge; valid never depends on ready, and ready comes only from registers.
  logic main_valid;
  logic skid_valid;
  T     main_data;
  T     skid_data;
  logic in_fire;
  logic out_fire;

  assign in_ready  = !skid_valid && !hold;
  assign out_valid = main_valid && !hold;
  assign out_data  = main_data;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (out_fire) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        skid_valid <= in_fire;
        if (in_fire) skid_data <= in_data;
      end else if (in_fire) begin
        main_data <= in_data;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (!main_valid) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// Registered instruction decode stage with a two-entry skid buffer and delivered-word counter.
// Define DECODE_ILLEGAL_TRAP_EN to enable the illegal-instruction check and TRAP state.
module instruction_decode_stage
  import decode_pkg::*;
#(
  parameter int OPCODE_WIDTH   = 5,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int REGISTER_WIDTH = 3,
  parameter int NUM_OPCODES    = 24,
  parameter int COUNT_WIDTH    = 16,
  localparam int INSTRUCTION_WIDTH = instruction_width(REGISTER_WIDTH, OPCODE_WIDTH, ADDRESS_WIDTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [OPCODE_WIDTH-1:0]      opCode,
  output logic [REGISTER_WIDTH-1:0]    registerWithAddress,
  output logic [ADDRESS_WIDTH-1:0]     address1In,
  output logic [ADDRESS_WIDTH-1:0]     address2In,
  output logic [ADDRESS_WIDTH-1:0]     addressOut,
  output logic [1:0]                   address1Type,
  output logic [1:0]                   address2Type,
  output logic [1:0]                   outType,
  output logic [REGISTER_WIDTH-1:0]    register1In,
  output logic [REGISTER_WIDTH-1:0]    register2In,
  output logic [REGISTER_WIDTH-1:0]    registerOut,
  output logic [ADDRESS_WIDTH-1:0]     instructionValue,
  output logic                         illegal,
  output logic                         trapped,
  input  logic                         trapClear,
  output logic [COUNT_WIDTH-1:0]       decodedCount,
  output state_e                       debugState
);

  localparam int OP_LSB  = opcode_lsb(ADDRESS_WIDTH);
  localparam int RWA_LSB = register_with_address_lsb(ADDRESS_WIDTH, OPCODE_WIDTH);
  localparam int A1_LSB  = address1_lsb(ADDRESS_WIDTH);
  localparam int A2_LSB  = address2_lsb(ADDRESS_WIDTH);
  localparam int AO_LSB  = address_out_lsb();
  localparam int T1_LSB  = address1_type_lsb();
  localparam int T2_LSB  = address2_type_lsb();
  localparam int TO_LSB  = out_type_lsb();
  localparam logic [OPCODE_WIDTH:0] NUM_OPCODES_L = (OPCODE_WIDTH + 1)'(NUM_OPCODES);

  typedef struct packed {
    logic [REGISTER_WIDTH-1:0] rwa;
    logic [OPCODE_WIDTH-1:0]   op;
    logic [ADDRESS_WIDTH-1:0]  a1;
    logic [ADDRESS_WIDTH-1:0]  a2;
    logic [ADDRESS_WIDTH-1:0]  ao;
    operand_type_e             t1;
    operand_type_e             t2;
    operand_type_e             to;
    logic                      illegal;
  } fields_t;

  fields_t dec_fields;
  fields_t out_fields;
  logic    illegal_raw;
  logic    hold;
  logic    out_fire;
  state_e  state;

  assign dec_fields.rwa = instruction[RWA_LSB +: REGISTER_WIDTH];
  assign dec_fields.op  = instruction[OP_LSB +: OPCODE_WIDTH];
  assign dec_fields.a1  = instruction[A1_LSB +: ADDRESS_WIDTH];
  assign dec_fields.a2  = instruction[A2_LSB +: ADDRESS_WIDTH];
  assign dec_fields.ao  = instruction[AO_LSB +: ADDRESS_WIDTH];
  assign dec_fields.t1  = operand_type_e'(instruction[T1_LSB +: TYPE_WIDTH]);
  assign dec_fields.t2  = operand_type_e'(instruction[T2_LSB +: TYPE_WIDTH]);
  assign dec_fields.to  = operand_type_e'(instruction[TO_LSB +: TYPE_WIDTH]);

  // An immediate can never be a destination, so outType == IMMEDIATE is illegal too.
  assign illegal_raw = ({1'b0, dec_fields.op} >= NUM_OPCODES_L) || (dec_fields.to == IMMEDIATE);

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign dec_fields.illegal = illegal_raw;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (out_fire && out_fields.illegal) state <= TRAP;
        TRAP:    if (trapClear) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
`else
  logic unused_trap_inputs;
  assign unused_trap_inputs = trapClear ^ illegal_raw;
  assign dec_fields.illegal = 1'b0;
  assign state = RUN;
`endif

  assign hold       = (state == TRAP);
  assign trapped    = hold;
  assign debugState = state;

  decode_skid_buffer #(
    .T(fields_t)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .hold      (hold),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (dec_fields),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (out_fields)
  );

  assign out_fire = outValid && outReady;

  always_ff @(posedge clock) begin
    if (reset) decodedCount <= '0;
    else if (out_fire) decodedCount <= decodedCount + 1'b1;
  end

  assign opCode              = out_fields.op;
  assign registerWithAddress = out_fields.rwa;
  assign address1In          = out_fields.a1;
  assign address2In          = out_fields.a2;
  assign addressOut          = out_fields.ao;
  assign address1Type        = out_fields.t1;
  assign address2Type        = out_fields.t2;
  assign outType             = out_fields.to;
  assign register1In         = out_fields.a1[REGISTER_WIDTH-1:0];
  assign register2In         = out_fields.a2[REGISTER_WIDTH-1:0];
  assign registerOut         = out_fields.ao[REGISTER_WIDTH-1:0];
  assign instructionValue    = out_fields.a2;
  assign illegal             = outValid && out_fields.illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench for instruction_decode_stage: in-flight word queue model plus directed vectors.
// Follows DECODE_ILLEGAL_TRAP_EN for the trap scenario; DUT built with a 4-bit counter to exercise wrap.
module tb_instruction_decode_stage;
  import decode_pkg::*;

  localparam int OW  = 5;
  localparam int AW  = 8;
  localparam int RW  = 3;
  localparam int NOP = 24;
  localparam int CW  = 4;
  localparam int IW  = 38;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [IW-1:0] instruction = '0;
  logic          outValid;
  logic          outReady = 1'b0;
  logic [OW-1:0] opCode;
  logic [RW-1:0] registerWithAddress, register1In, register2In, registerOut;
  logic [AW-1:0] address1In, address2In, addressOut, instructionValue;
  logic [1:0]    address1Type, address2Type, outType;
  logic          illegal, trapped;
  logic          trapClear = 1'b0;
  logic [CW-1:0] decodedCount;
  state_e        debugState;

  instruction_decode_stage #(
    .OPCODE_WIDTH(OW), .ADDRESS_WIDTH(AW), .REGISTER_WIDTH(RW),
    .NUM_OPCODES(NOP), .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .instruction(instruction), .outValid(outValid), .outReady(outReady),
    .opCode(opCode), .registerWithAddress(registerWithAddress),
    .address1In(address1In), .address2In(address2In), .addressOut(addressOut),
    .address1Type(address1Type), .address2Type(address2Type), .outType(outType),
    .register1In(register1In), .register2In(register2In), .registerOut(registerOut),
    .instructionValue(instructionValue), .illegal(illegal), .trapped(trapped),
    .trapClear(trapClear), .decodedCount(decodedCount), .debugState(debugState)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          failures = 0;
  logic [IW-1:0] exp_q[$];
  logic [CW-1:0] exp_count = '0;
  bit          model_trap = 1'b0;
  int          delivered = 0;
  int          accepted = 0;
  bit          prod_done = 1'b0;

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    failures++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Field at bit position lsb of width bits, layout fixed by the default parameters.
  function automatic longint fld(input logic [IW-1:0] w, input int lsb, input int width);
    return (longint'(w) >> lsb) & ((longint'(1) << width) - 1);
  endfunction

  function automatic bit model_illegal(input logic [IW-1:0] w);
`ifdef DECODE_ILLEGAL_TRAP_EN
    return (fld(w, 30, 5) >= NOP) || (fld(w, 0, 2) == 3);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [IW-1:0] mk(input int rwa, input int op, input int a1, input int a2,
                                       input int ao, input int t1, input int t2, input int to);
    return {3'(rwa), 5'(op), 8'(a1), 8'(a2), 8'(ao), 2'(t1), 2'(t2), 2'(to)};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    logic [IW-1:0] w;
    if (reset) begin
      exp_q.delete();
      exp_count  = '0;
      model_trap = 1'b0;
      delivered  = 0;
      accepted   = 0;
    end else begin
      check("out_valid", outValid, !model_trap && exp_q.size() > 0);
      check("in_ready", inReady, !model_trap && exp_q.size() < 2);
      check("decoded_count", decodedCount, exp_count);
      check("trapped", trapped, model_trap);
      if (outValid && outReady && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("reg_with_addr", registerWithAddress, fld(w, 35, 3));
        check("opcode", opCode, fld(w, 30, 5));
        check("address1", address1In, fld(w, 22, 8));
        check("address2", address2In, fld(w, 14, 8));
        check("address_out", addressOut, fld(w, 6, 8));
        check("type1", address1Type, fld(w, 4, 2));
        check("type2", address2Type, fld(w, 2, 2));
        check("out_type", outType, fld(w, 0, 2));
        check("register1", register1In, fld(w, 22, 3));
        check("register2", register2In, fld(w, 14, 3));
        check("register_out", registerOut, fld(w, 6, 3));
        check("instr_value", instructionValue, fld(w, 14, 8));
        check("illegal", illegal, model_illegal(w));
        exp_count = exp_count + 1'b1;
        delivered++;
        if (model_illegal(w)) model_trap = 1'b1;
      end else if (model_trap && trapClear) begin
        model_trap = 1'b0;
      end
      if (inValid && inReady) begin
        exp_q.push_back(instruction);
        accepted++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the word.
  task automatic send_word(input logic [IW-1:0] w);
    int budget;
    budget = 0;
    instruction = w;
    inValid = 1'b1;
    @(negedge clock);
    while (!inReady && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    if (!inReady) timeout_fail("send_word");
    step();
    inValid = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    inValid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() > 0 && budget < 500) begin
      @(negedge clock);
      budget++;
    end
    if (exp_q.size() > 0) timeout_fail("drain");
    step();
    @(negedge clock);
  endtask

  // ---------------- directed and random stimulus ----------------
  logic [IW-1:0] words[8];

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_out_valid", outValid, 0);
    check("rst_in_ready", inReady, 1);
    check("rst_illegal", illegal, 0);
    check("rst_trapped", trapped, 0);
    check("rst_count", decodedCount, 0);
    check("rst_opcode", opCode, 0);
    check("rst_address1", address1In, 0);
    check("rst_instr_value", instructionValue, 0);

    // Single word: registers come from the low 3 bits of each address.
    step();
    outReady = 1'b1;
    send_word(mk(0, 3, 'h12, 'h34, 'h56, 0, 1, 0));
    @(negedge clock);
    check("t1_out_valid", outValid, 1);
    check("t1_opcode", opCode, 3);
    check("t1_register1", register1In, 2);
    check("t1_register2", register2In, 4);
    check("t1_register_out", registerOut, 6);
    check("t1_instr_value", instructionValue, 'h34);
    check("t1_type2", address2Type, 1);
    @(negedge clock);
    check("t1_count", decodedCount, 1);
    check("t1_out_valid_after", outValid, 0);

    // Backpressure: only two words fit while outReady is low.
    step();
    outReady = 1'b0;
    reset_dut();
    for (int i = 0; i < 8; i++)
      words[i] = mk(i, i + 1, 16 * i + 1, 16 * i + 2, 16 * i + 3, i % 3, (i + 1) % 3, (i + 2) % 3);
    send_word(words[0]);
    send_word(words[1]);
    instruction = words[2];
    inValid = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("bp_in_ready", inReady, 0);
      check("bp_opcode_held", opCode, 1);
    end
    step();
    outReady = 1'b1;
    for (int i = 2; i < 8; i++) send_word(words[i]);
    drain();
    check("bp_count", decodedCount, 8);

    // 17 transfers on a 4-bit counter wrap to 1.
    step();
    reset_dut();
    for (int i = 0; i < 17; i++) send_word(mk(i % 8, i % 24, i, 2 * i, 3 * i, 1, 2, 0));
    drain();
    check("wrap_count", decodedCount, 1);

    // Reset with two words buffered discards them.
    step();
    outReady = 1'b0;
    send_word(mk(1, 2, 3, 4, 5, 0, 0, 0));
    send_word(mk(2, 3, 4, 5, 6, 0, 0, 0));
    @(negedge clock);
    check("full_in_ready", inReady, 0);
    step();
    reset_dut();
    @(negedge clock);
    check("rstmid_out_valid", outValid, 0);
    check("rstmid_count", decodedCount, 0);
    check("rstmid_in_ready", inReady, 1);

    // Illegal opcode followed by a legal one.
    step();
    outReady = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
    send_word(mk(1, 30, 1, 2, 3, 0, 0, 0));
    instruction = mk(2, 5, 7, 8, 9, 0, 1, 2);
    inValid = 1'b1;
    @(negedge clock);
    check("trap_illegal", illegal, 1);
    check("trap_in_ready_pre", inReady, 1);
    step();
    inValid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("trap_trapped", trapped, 1);
      check("trap_out_valid", outValid, 0);
      check("trap_in_ready", inReady, 0);
      step();
    end
    trapClear = 1'b1;
    step();
    trapClear = 1'b0;
    @(negedge clock);
    check("clear_trapped", trapped, 0);
    check("clear_out_valid", outValid, 1);
    check("clear_opcode", opCode, 5);
    drain();
`else
    send_word(mk(1, 30, 1, 2, 3, 3, 3, 3));
    instruction = mk(2, 5, 7, 8, 9, 0, 1, 2);
    inValid = 1'b1;
    @(negedge clock);
    check("noil_illegal", illegal, 0);
    check("noil_out_valid", outValid, 1);
    check("noil_opcode", opCode, 30);
    step();
    inValid = 1'b0;
    @(negedge clock);
    check("noil_trapped", trapped, 0);
    check("noil_next_opcode", opCode, 5);
    drain();
`endif

    // Random handshakes over 1000 legal words.
    step();
    reset_dut();
    prod_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          repeat ($urandom_range(0, 2)) step();
          send_word(mk($urandom_range(0, 7), $urandom_range(0, NOP - 1), $urandom_range(0, 255),
                       $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 2)));
        end
        prod_done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while ((!prod_done || exp_q.size() > 0) && cyc < 20000) begin
          step();
          outReady = 1'($urandom_range(0, 1));
          cyc++;
        end
        if (cyc >= 20000) timeout_fail("random_consumer");
        outReady = 1'b1;
      end
    join
    drain();
    check("rand_accepted", accepted, 1000);
    check("rand_delivered", delivered, 1000);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
